// File: rtl/idli_sqi_mem_m.sv
// Responder end of the SQI link: a 23LC512-style SRAM model in sequential SQI
// mode. Decodes instruction (0x03 read / 0x02 write), a 16-bit big-endian
// address and, for reads, a dummy byte. It then streams read data or accepts
// write data, incrementing the address after each byte.
// Ports:
//   i_mem_gck      clock
//   i_mem_rst      synchronous active-high reset
//   i_mem_cs       chip select, active low
//   i_mem_sck_en   SCK pulse this cycle (clock-enable form)
//   i_mem_data     nibble from controller
//   o_mem_data     nibble to controller (registered, 0 when not driving)
//   o_mem_oe       responder drives pins (read data phase)
//   o_mem_err      one-cycle pulse on unsupported instruction
//   i_mem_bd_*     backdoor byte write port for preloading storage
module idli_sqi_mem_m #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_mem_gck,
    input  logic              i_mem_rst,
    input  logic              i_mem_cs,
    input  logic              i_mem_sck_en,
    input  logic [3:0]        i_mem_data,
    output logic [3:0]        o_mem_data,
    output logic              o_mem_oe,
    output logic              o_mem_err,
    input  logic              i_mem_bd_we,
    input  logic [ADDR_W-1:0] i_mem_bd_addr,
    input  logic [7:0]        i_mem_bd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_INSTR,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ctr_q, ctr_d;
    logic [15:0] addr_q, addr_d;
    logic        rd_q, rd_d;
    logic [3:0]  nib_q, nib_d;
    logic        oe_q, oe_d;
    logic [3:0]  data_q, data_d;
    logic        err_q, err_d;

    logic [7:0]  mem_q [DEPTH];

    logic [15:0] addr_inc_c;
    logic [7:0]  rd_byte_c;
    logic [7:0]  rd_next_c;
    logic        wr_en_c;
    logic [7:0]  wr_data_c;

    assign addr_inc_c = addr_q + 16'd1;
    assign rd_byte_c  = mem_q[addr_q[ADDR_W-1:0]];
    assign rd_next_c  = mem_q[addr_inc_c[ADDR_W-1:0]];

    // Next-state / output decode; only SCK-enabled cycles with CS low advance.
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        nib_d     = nib_q;
        oe_d      = oe_q;
        data_d    = data_q;
        err_d     = 1'b0;
        wr_en_c   = 1'b0;
        wr_data_c = 8'h00;

        if (i_mem_cs) begin
            state_d = ST_INSTR;
            ctr_d   = 2'd0;
            oe_d    = 1'b0;
            data_d  = 4'h0;
        end else if (i_mem_sck_en) begin
            case (state_q)
                ST_INSTR: begin
                    if (ctr_q[0] == 1'b0) begin
                        nib_d = i_mem_data;
                        ctr_d = 2'd1;
                    end else begin
                        ctr_d = 2'd0;
                        if ({nib_q, i_mem_data} == 8'h03) begin
                            state_d = ST_ADDR;
                            rd_d    = 1'b1;
                        end else if ({nib_q, i_mem_data} == 8'h02) begin
                            state_d = ST_ADDR;
                            rd_d    = 1'b0;
                        end else begin
                            state_d = ST_IGNORE;
                            err_d   = 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    addr_d = {addr_q[11:0], i_mem_data};
                    ctr_d  = ctr_q + 2'd1;
                    if (ctr_q == 2'd3) begin
                        ctr_d   = 2'd0;
                        state_d = rd_q ? ST_DUMMY : ST_WDATA;
                    end
                end
                ST_DUMMY: begin
                    if (ctr_q[0] == 1'b0) begin
                        ctr_d = 2'd1;
                    end else begin
                        ctr_d   = 2'd0;
                        state_d = ST_RDATA;
                        oe_d    = 1'b1;
                        data_d  = rd_byte_c[7:4];
                    end
                end
                // ctr[0] tracks which half of the current byte is on the pins.
                ST_RDATA: begin
                    if (ctr_q[0] == 1'b0) begin
                        data_d = rd_byte_c[3:0];
                        ctr_d  = 2'd1;
                    end else begin
                        addr_d = addr_inc_c;
                        data_d = rd_next_c[7:4];
                        ctr_d  = 2'd0;
                    end
                end
                ST_WDATA: begin
                    if (ctr_q[0] == 1'b0) begin
                        nib_d = i_mem_data;
                        ctr_d = 2'd1;
                    end else begin
                        wr_en_c   = 1'b1;
                        wr_data_c = {nib_q, i_mem_data};
                        addr_d    = addr_inc_c;
                        ctr_d     = 2'd0;
                    end
                end
                ST_IGNORE: begin
                    oe_d   = 1'b0;
                    data_d = 4'h0;
                end
                default: begin
                    state_d = ST_INSTR;
                    ctr_d   = 2'd0;
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            state_q <= ST_INSTR;
            ctr_q   <= 2'd0;
            addr_q  <= 16'h0000;
            rd_q    <= 1'b0;
            nib_q   <= 4'h0;
            oe_q    <= 1'b0;
            data_q  <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            nib_q   <= nib_d;
            oe_q    <= oe_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Storage: not reset. The SQI write is ordered last so it wins a collision.
    always_ff @(posedge i_mem_gck) begin
        if (i_mem_bd_we) begin
            mem_q[i_mem_bd_addr] <= i_mem_bd_data;
        end
        if (wr_en_c && !i_mem_rst) begin
            mem_q[addr_q[ADDR_W-1:0]] <= wr_data_c;
        end
    end

    assign o_mem_data = data_q;
    assign o_mem_oe   = oe_q;
    assign o_mem_err  = err_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Bench for idli_sqi_mem_m: directed scenarios then random read/write/bad
// transactions against a byte-array model; a monitor checks every cycle.
module tb_idli_sqi_mem_m;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_i;
    logic       en_i;
    logic [3:0] data_i;
    logic [3:0] data_o;
    logic       oe_o;
    logic       err_o;
    logic       bd_we;
    logic [7:0] bd_addr;
    logic [7:0] bd_data;

    always #5 clk = ~clk;

    idli_sqi_mem_m #(.ADDR_W(8)) dut (
        .i_mem_gck    (clk),
        .i_mem_rst    (rst),
        .i_mem_cs     (cs_i),
        .i_mem_sck_en (en_i),
        .i_mem_data   (data_i),
        .o_mem_data   (data_o),
        .o_mem_oe     (oe_o),
        .o_mem_err    (err_o),
        .i_mem_bd_we  (bd_we),
        .i_mem_bd_addr(bd_addr),
        .i_mem_bd_data(bd_data)
    );

    logic [7:0] mm [256];
    logic [7:0] wbuf [16];
    logic [3:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         gap_mode = 0;
    bit         exp_err_next = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: inputs applied, edge, return 1 time unit after the edge.
    task automatic tick(input logic cs, input logic en, input logic [3:0] nib);
        cs_i   = cs;
        en_i   = en;
        data_i = nib;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    // Optional SCK-idle gap (cs low, junk on data) then one clocked nibble.
    task automatic send_nib(input logic [3:0] nib, input int gap);
        int g;
        if (gap >= 0) g = gap;
        else if (gap_mode >= 0) g = gap_mode;
        else g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        repeat (g) tick(1'b0, 1'b0, 4'($urandom));
        tick(1'b0, 1'b1, nib);
    endtask

    task automatic send_addr(input logic [15:0] a);
        send_nib(a[15:12], -1);
        send_nib(a[11:8], -1);
        send_nib(a[7:4], -1);
        send_nib(a[3:0], -1);
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        mm[a]   = d;
        tick(1'b1, 1'b0, 4'h0);
    endtask

    // Read n nibbles from address a; nibble k is half of byte (a + k/2) mod 256.
    task automatic do_read(input logic [15:0] a, input int n, input bit rst_end);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = mm[8'((int'(a) + k / 2) & 255)];
            exp_q.push_back((k % 2 == 0) ? b[7:4] : b[3:0]);
        end
        send_nib(4'h0, -1);
        send_nib(4'h3, -1);
        send_addr(a);
        send_nib(4'($urandom), -1);
        send_nib(4'($urandom), -1);
        for (int k = 1; k < n; k++) send_nib(4'($urandom), -1);
        if (rst_end) begin
            rst = 1'b1;
            tick(1'b0, 1'b1, 4'($urandom));
            rst = 1'b0;
            chk("rst_oe", {7'd0, oe_o}, 8'h00);
            chk("rst_data", {4'd0, data_o}, 8'h00);
        end
        tick(1'b1, 1'b0, 4'h0);
        chk("rd_drain", 8'(exp_q.size()), 8'h00);
        exp_q.delete();
    endtask

    // Write nb bytes from wbuf at a; odd adds a trailing lone nibble (discarded).
    task automatic do_write(input logic [15:0] a, input int nb, input bit odd, input bit collide);
        logic [7:0] idx;
        send_nib(4'h0, -1);
        send_nib(4'h2, -1);
        send_addr(a);
        for (int i = 0; i < nb; i++) begin
            idx = 8'((int'(a) + i) & 255);
            send_nib(wbuf[i][7:4], -1);
            if (collide) begin
                bd_we   = 1'b1;
                bd_addr = idx;
                bd_data = 8'($urandom);
                send_nib(wbuf[i][3:0], 0);
            end else begin
                send_nib(wbuf[i][3:0], -1);
            end
            mm[idx] = wbuf[i];
        end
        if (odd) send_nib(4'($urandom), -1);
        tick(1'b1, 1'b0, 4'h0);
    endtask

    // Unsupported instruction followed by nibbles that must write nothing.
    task automatic do_bad(input logic [7:0] instr, input int extra);
        send_nib(instr[7:4], -1);
        exp_err_next = 1'b1;
        send_nib(instr[3:0], -1);
        exp_err_next = 1'b0;
        for (int i = 0; i < extra; i++) send_nib(4'($urandom), -1);
        tick(1'b1, 1'b0, 4'h0);
    endtask

    // Monitor: classifies each edge from the inputs seen there, checks after.
    initial begin
        logic       idle;
        logic       adv;
        logic       e_err;
        logic       prev_oe;
        logic [3:0] prev_data;
        logic [3:0] e;
        prev_oe   = 1'b0;
        prev_data = 4'h0;
        forever begin
            @(posedge clk);
            idle  = rst || cs_i;
            adv   = !idle && en_i;
            e_err = exp_err_next && adv;
            @(negedge clk);
            chk("err", {7'd0, err_o}, {7'd0, e_err});
            if (idle) begin
                chk("idle_oe", {7'd0, oe_o}, 8'h00);
                chk("idle_data", {4'd0, data_o}, 8'h00);
            end else if (adv && oe_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got oe=1 data=%h expected oe=0 at %0t", data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_nib", {4'd0, data_o}, {4'd0, e});
                end
            end else if (adv) begin
                chk("noe_data", {4'd0, data_o}, 8'h00);
            end else begin
                chk("hold_oe", {7'd0, oe_o}, {7'd0, prev_oe});
                chk("hold_data", {4'd0, data_o}, {4'd0, prev_data});
            end
            prev_oe   = oe_o;
            prev_data = data_o;
        end
    end

    logic [7:0] bad;

    initial begin
        rst     = 1'b1;
        cs_i    = 1'b1;
        en_i    = 1'b0;
        data_i  = 4'h0;
        bd_we   = 1'b0;
        bd_addr = 8'h00;
        bd_data = 8'h00;
        tick(1'b1, 1'b0, 4'h0);
        tick(1'b0, 1'b1, 4'h3);
        chk("reset_oe", {7'd0, oe_o}, 8'h00);
        chk("reset_data", {4'd0, data_o}, 8'h00);
        chk("reset_err", {7'd0, err_o}, 8'h00);
        rst = 1'b0;
        tick(1'b1, 1'b0, 4'h0);

        for (int i = 0; i < 256; i++) bd_write(8'(i), 8'($urandom));

        gap_mode = 0;
        // Basic read A,5,3,C
        bd_write(8'h10, 8'hA5);
        bd_write(8'h11, 8'h3C);
        do_read(16'h0010, 4, 1'b0);
        // Write 7E,41 at 0x20 and read it back
        wbuf[0] = 8'h7E;
        wbuf[1] = 8'h41;
        do_write(16'h0020, 2, 1'b0, 1'b0);
        do_read(16'h0020, 4, 1'b0);
        // Address wrap 0xFFFF -> 0x0000
        bd_write(8'hFF, 8'h12);
        bd_write(8'h00, 8'h34);
        do_read(16'hFFFF, 4, 1'b0);
        // Unsupported instruction, then normal read
        do_bad(8'h05, 6);
        do_read(16'h0010, 4, 1'b0);
        // Lone write nibble is discarded
        do_write(16'h0030, 0, 1'b1, 1'b0);
        do_read(16'h0030, 2, 1'b0);
        // Reset mid-read
        do_read(16'h0010, 3, 1'b1);
        // SQI write wins a same-cycle backdoor collision
        wbuf[0] = 8'hC3;
        do_write(16'h0040, 1, 1'b0, 1'b1);
        do_read(16'h0040, 2, 1'b0);
        // 3-cycle SCK gaps everywhere: same data expected
        gap_mode = 3;
        do_read(16'h0010, 4, 1'b0);

        gap_mode = -1;
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: do_read(16'($urandom), int'($urandom_range(1, 8)),
                                    $urandom_range(0, 7) == 0);
                4, 5, 6, 7: begin
                    for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
                    do_write(16'($urandom), int'($urandom_range(0, 4)),
                             1'($urandom), $urandom_range(0, 3) == 0);
                end
                8: begin
                    bad = 8'($urandom);
                    if (bad == 8'h02 || bad == 8'h03) bad = 8'hFF;
                    do_bad(bad, int'($urandom_range(0, 8)));
                end
                default: begin
                    bd_write(8'($urandom), 8'($urandom));
                    do_read(16'($urandom), int'($urandom_range(1, 6)), 1'b0);
                end
            endcase
        end

        tick(1'b1, 1'b0, 4'h0);
        tick(1'b1, 1'b0, 4'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
